// File: rtl/scc_init_sequencer.sv
// SCC init sequencer: replays a register table into the Z8530 using pointer/value
// write pairs, sharing the single SCC bus port with live CPU accesses on ph0 slots.
module scc_init_sequencer #(
    parameter int unsigned TABLE_LEN  = 16,
    parameter int unsigned GAP_SLOTS  = 2,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk_14m,
    input  logic        reset,
    input  logic        ph0_en,
    input  logic        start,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_rs,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait,
    output logic        scc_cs,
    output logic        scc_we,
    output logic [1:0]  scc_rs,
    output logic [7:0]  scc_wdata,
    input  logic [7:0]  scc_rdata,
    output logic [3:0]  tbl_idx,
    input  logic [12:0] tbl_entry,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR,
        S_VAL,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(TABLE_LEN - 1);
    localparam logic [2:0] GAP_LOAD = 3'(GAP_SLOTS);

    state_t      r_state, w_state_next;
    logic [3:0]  r_idx, w_idx_next;
    logic [2:0]  r_gap, w_gap_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic        r_pending, w_pending_next;

    logic        w_port;
    logic [3:0]  w_reg;
    logic [7:0]  w_val;
    logic        w_grant;
    logic        w_seq_cs;
    logic [7:0]  w_seq_wdata;

    assign w_port = tbl_entry[12];
    assign w_reg  = tbl_entry[11:8];
    assign w_val  = tbl_entry[7:0];

    always_ff @(posedge clk_14m or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_gap     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pending <= AUTO_START;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_gap     <= w_gap_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_pending <= w_pending_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_gap_next     = r_gap;
        w_busy_next    = r_busy;
        w_done_next    = r_done;
        w_pending_next = r_pending;
        w_grant        = 1'b1;
        w_seq_cs       = 1'b0;
        w_seq_wdata    = '0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (ph0_en && (start || r_pending)) begin
                    w_state_next   = S_PTR;
                    w_idx_next     = '0;
                    w_done_next    = 1'b0;
                    w_busy_next    = 1'b1;
                    w_pending_next = 1'b0;
                end
            end
            S_PTR: begin
                w_grant = 1'b0;
                if (w_reg == 4'hF) begin
                    if (ph0_en) begin
                        w_state_next = S_DONE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end
                end else if (w_reg == 4'h0) begin
                    // WR0 target: the value write itself lands in this slot
                    w_seq_cs    = ph0_en;
                    w_seq_wdata = w_val;
                    if (ph0_en) begin
                        w_gap_next   = GAP_LOAD;
                        w_state_next = S_GAP;
                    end
                end else begin
                    w_seq_cs    = ph0_en;
                    w_seq_wdata = {4'b0000, w_reg};
                    if (ph0_en) begin
                        w_state_next = S_VAL;
                    end
                end
            end
            S_VAL: begin
                w_grant     = 1'b0;
                w_seq_cs    = ph0_en;
                w_seq_wdata = w_val;
                if (ph0_en) begin
                    w_gap_next   = GAP_LOAD;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (ph0_en) begin
                    w_gap_next = r_gap - 3'd1;
                    if (r_gap <= 3'd1) begin
                        w_gap_next = '0;
                        if (r_idx == LAST_IDX) begin
                            w_state_next = S_DONE;
                            w_busy_next  = 1'b0;
                            w_done_next  = 1'b1;
                        end else begin
                            w_idx_next   = r_idx + 4'd1;
                            w_state_next = S_PTR;
                        end
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        scc_cs    = 1'b0;
        scc_we    = 1'b0;
        scc_rs    = '0;
        scc_wdata = '0;
        if (!reset) begin
            if (w_grant) begin
                scc_cs    = cpu_cs;
                scc_we    = cpu_we;
                scc_rs    = cpu_rs;
                scc_wdata = cpu_wdata;
            end else begin
                scc_cs    = w_seq_cs;
                scc_we    = w_seq_cs;
                scc_rs    = {1'b0, w_port};
                scc_wdata = w_seq_wdata;
            end
        end
    end

    assign cpu_wait  = cpu_cs & ~w_grant;
    assign cpu_rdata = scc_rdata;
    assign tbl_idx   = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_scc_init_sequencer.sv
// Directed bench for scc_init_sequencer: logs every SCC write per ph0 slot and
// compares against hand-derived write sequences, plus pass-through vectors.
module tb_scc_init_sequencer;

    logic        clk_14m = 1'b0;
    logic        reset;
    logic        ph0_en;
    logic        start;
    logic        cpu_cs;
    logic        cpu_we;
    logic [1:0]  cpu_rs;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic        scc_cs;
    logic        scc_we;
    logic [1:0]  scc_rs;
    logic [7:0]  scc_wdata;
    logic [7:0]  scc_rdata;
    logic [3:0]  tbl_idx;
    logic [12:0] tbl_entry;
    logic        busy;
    logic        done;

    logic [12:0] tbl_mem [16];
    assign tbl_entry = tbl_mem[tbl_idx];

    always #5 clk_14m = ~clk_14m;

    scc_init_sequencer #(
        .TABLE_LEN (16),
        .GAP_SLOTS (2),
        .AUTO_START(1'b1)
    ) dut (
        .clk_14m  (clk_14m),
        .reset    (reset),
        .ph0_en   (ph0_en),
        .start    (start),
        .cpu_cs   (cpu_cs),
        .cpu_we   (cpu_we),
        .cpu_rs   (cpu_rs),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_wait (cpu_wait),
        .scc_cs   (scc_cs),
        .scc_we   (scc_we),
        .scc_rs   (scc_rs),
        .scc_wdata(scc_wdata),
        .scc_rdata(scc_rdata),
        .tbl_idx  (tbl_idx),
        .tbl_entry(tbl_entry),
        .busy     (busy),
        .done     (done)
    );

    // one ph0 slot every 4 clocks, one clock wide
    initial begin
        ph0_en = 1'b0;
        forever begin
            repeat (3) @(posedge clk_14m);
            #1 ph0_en = 1'b1;
            @(posedge clk_14m);
            #1 ph0_en = 1'b0;
        end
    end

    int          slot_no = 0;
    logic [9:0]  log_data [$];
    int          log_slot [$];
    logic [9:0]  exp_data [$];

    always @(negedge clk_14m) begin
        if (ph0_en) begin
            if (scc_cs && scc_we) begin
                log_data.push_back({scc_rs, scc_wdata});
                log_slot.push_back(slot_no);
            end
            slot_no <= slot_no + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_slot();
        int n = 0;
        do begin
            @(negedge clk_14m);
            n++;
        end while (!ph0_en && n < 20);
        chk("slot_timeout", ph0_en, 1'b1);
    endtask

    task automatic pulse_start();
        wait_slot();
        start = 1'b1;
        @(posedge clk_14m);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!(done === 1'b1 && busy === 1'b0) && n < budget) begin
            @(negedge clk_14m);
            n++;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic clear_log();
        log_data.delete();
        log_slot.delete();
        exp_data.delete();
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, log_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < log_data.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), log_data[i], exp_data[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_scc_cs"}, scc_cs, 1'b0);
        chk({tag, "_scc_we"}, scc_we, 1'b0);
        chk({tag, "_scc_rs"}, scc_rs, 2'b00);
        chk({tag, "_scc_wdata"}, scc_wdata, 8'h00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_wait"}, cpu_wait, 1'b0);
        chk({tag, "_idx"}, tbl_idx, 4'd0);
    endtask

    typedef struct {
        logic        cs;
        logic        we;
        logic [1:0]  rs;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic [19:0] exp;   // {scc_cs, scc_we, scc_rs, scc_wdata, cpu_rdata}
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{cs: 1'b1, we: 1'b1, rs: 2'b00, wd: 8'h3C, rd: 8'h00, exp: 20'hC_3C_00};
        vecs[1] = '{cs: 1'b1, we: 1'b0, rs: 2'b11, wd: 8'h00, rd: 8'hA5, exp: 20'hB_00_A5};
        vecs[2] = '{cs: 1'b0, we: 1'b0, rs: 2'b00, wd: 8'h00, rd: 8'h7E, exp: 20'h0_00_7E};
        vecs[3] = '{cs: 1'b1, we: 1'b1, rs: 2'b10, wd: 8'hFF, rd: 8'h01, exp: 20'hE_FF_01};

        reset = 1'b1; start = 1'b0;
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_rs = 2'b10; cpu_wdata = 8'hAB;
        scc_rdata = 8'h00;
        for (int i = 0; i < 16; i++) tbl_mem[i] = 13'h0F00;
        tbl_mem[0] = {1'b1, 4'h9, 8'hC0};
        tbl_mem[1] = {1'b0, 4'h4, 8'h44};

        // reset state, with a CPU request present that must not leak through
        repeat (6) @(negedge clk_14m);
        check_reset_outputs("rst");
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_rs = 2'b00; cpu_wdata = 8'h00;

        // auto-start replay of the two-entry table
        clear_log();
        reset = 1'b0;
        wait_done("auto", 400);
        exp_data = '{{2'b01, 8'h09}, {2'b01, 8'hC0}, {2'b00, 8'h04}, {2'b00, 8'h44}};
        check_log("auto");
        if (log_slot.size() == 4) begin
            chk("auto_slot_ptr_val", log_slot[1] - log_slot[0], 1);
            chk("auto_slot_gap", log_slot[2] - log_slot[1], 3);
            chk("auto_slot_ptr_val2", log_slot[3] - log_slot[2], 1);
        end
        chk("auto_idx", tbl_idx, 4'd2);

        // pass-through vectors in DONE: zero latency, no clock edge in between
        clear_log();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_14m);
            cpu_cs = vecs[i].cs; cpu_we = vecs[i].we; cpu_rs = vecs[i].rs;
            cpu_wdata = vecs[i].wd; scc_rdata = vecs[i].rd;
            #1;
            chk($sformatf("pass_v%0d", i), {scc_cs, scc_we, scc_rs, scc_wdata, cpu_rdata}, vecs[i].exp);
            chk($sformatf("pass_wait_v%0d", i), cpu_wait, 1'b0);
        end
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_rs = 2'b00; cpu_wdata = 8'h00;

        // reg0 entry: value write only, no pointer write
        tbl_mem[0] = {1'b0, 4'h0, 8'h10};
        tbl_mem[1] = 13'h0F00;
        clear_log();
        pulse_start();
        chk("r0_busy_after_start", busy, 1'b1);
        chk("r0_done_cleared", done, 1'b0);
        wait_done("r0", 400);
        exp_data = '{{2'b00, 8'h10}};
        check_log("r0");
        chk("r0_idx", tbl_idx, 4'd1);

        // CPU read of C03B held across the pointer/value pair
        tbl_mem[0] = {1'b1, 4'h9, 8'hC0};
        clear_log();
        pulse_start();
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_rs = 2'b11; cpu_wdata = 8'h00; scc_rdata = 8'h5A;
        #1;
        chk("rd_wait_early", cpu_wait, 1'b1);
        chk("rd_no_forward", scc_cs, 1'b0);
        wait_slot();
        chk("rd_ptr_wait", cpu_wait, 1'b1);
        chk("rd_ptr_bus", {scc_cs, scc_we, scc_rs, scc_wdata}, {1'b1, 1'b1, 2'b01, 8'h09});
        wait_slot();
        chk("rd_val_wait", cpu_wait, 1'b1);
        chk("rd_val_bus", {scc_cs, scc_we, scc_rs, scc_wdata}, {1'b1, 1'b1, 2'b01, 8'hC0});
        wait_slot();
        chk("rd_gap_wait", cpu_wait, 1'b0);
        chk("rd_gap_bus", {scc_cs, scc_we, scc_rs}, {1'b1, 1'b0, 2'b11});
        chk("rd_gap_rdata", cpu_rdata, 8'h5A);
        @(posedge clk_14m);
        #1 cpu_cs = 1'b0; cpu_rs = 2'b00;
        wait_done("rd", 400);

        // full 16-entry table, then replay with an ignored mid-run start
        for (int i = 0; i < 16; i++)
            tbl_mem[i] = {i[0], 4'((i % 14) + 1), 8'((i * 29) + 3)};
        clear_log();
        for (int i = 0; i < 16; i++) begin
            exp_data.push_back({1'b0, tbl_mem[i][12], 4'h0, tbl_mem[i][11:8]});
            exp_data.push_back({1'b0, tbl_mem[i][12], tbl_mem[i][7:0]});
        end
        pulse_start();
        wait_done("full", 3000);
        check_log("full");
        chk("full_idx", tbl_idx, 4'd15);

        log_data.delete();
        log_slot.delete();
        pulse_start();
        chk("replay_idx0", tbl_idx, 4'd0);
        chk("replay_busy", busy, 1'b1);
        chk("replay_done_clr", done, 1'b0);
        for (int n = 0; n < 400 && tbl_idx < 4'd3; n++) @(negedge clk_14m);
        pulse_start();
        chk("busy_start_idx", tbl_idx >= 4'd3, 1'b1);
        chk("busy_start_busy", busy, 1'b1);
        wait_done("replay", 3000);
        check_log("replay");

        // reset between pointer and value writes
        for (int i = 0; i < 16; i++) tbl_mem[i] = 13'h0F00;
        tbl_mem[0] = {1'b1, 4'h9, 8'hC0};
        clear_log();
        pulse_start();
        wait_slot();
        @(posedge clk_14m);
        #1 reset = 1'b1;
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_rs = 2'b01; cpu_wdata = 8'h77;
        #2;
        check_reset_outputs("midrst");
        repeat (10) @(negedge clk_14m);
        exp_data = '{{2'b01, 8'h09}};
        check_log("midrst");
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_rs = 2'b00; cpu_wdata = 8'h00;
        clear_log();
        reset = 1'b0;
        wait_done("restart", 400);
        exp_data = '{{2'b01, 8'h09}, {2'b01, 8'hC0}};
        check_log("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
